// File: rtl/frame_stats_snapshot.sv
// Per-frame byte/good/bad counters with periodic or requested coherent snapshots for a bus_cdc.
// Latency: snapshot event at cycle N -> snapshot_trigger and new snapshot_data at N+1; no backpressure.
module frame_stats_snapshot #(
  parameter int CNT_W      = 64,
  parameter int LEN_W      = 16,
  parameter int MIN_PERIOD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               snap_req,
  input  logic [31:0]        sample_period,
  input  logic               frame_valid,
  input  logic [LEN_W-1:0]   frame_bytes,
  input  logic               frame_error,
  output logic [3*CNT_W-1:0] snapshot_data,
  output logic               snapshot_trigger
);

  localparam int GAP_W = $clog2(MIN_PERIOD) + 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_PERIOD - 1);
  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic   run;

  logic [CNT_W-1:0] bytes_q, good_q, bad_q;
  logic [CNT_W-1:0] bytes_n, good_n, bad_n;
  logic [31:0]      timer_q, timer_d, eff_period;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pend_q, pend_d;
  logic             count, tmr_fire, gap_ok, snap_want, snap_go, snap_evt;

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        state_d = RUN;
        run     = 1'b1;
      end
      RUN: if (enable) run = 1'b1;
           else        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next-state counter values include this cycle's frame; the snapshot takes these pre-clear.
  always_comb begin
    count   = run & frame_valid;
    bytes_n = bytes_q + (count ? CNT_W'(frame_bytes) : '0);
    good_n  = good_q + CNT_W'(count & ~frame_error);
    bad_n   = bad_q + CNT_W'(count & frame_error);
  end

  always_comb begin
    eff_period = (sample_period < MIN_P) ? MIN_P : sample_period;
    tmr_fire   = run && (sample_period != 32'd0) && (timer_q >= eff_period - 32'd1);
    gap_ok     = (gap_q >= GAP_MAX);
    snap_want  = snap_req | pend_q;
    snap_go    = snap_want & gap_ok;
    pend_d     = snap_want & ~gap_ok;
    snap_evt   = tmr_fire | snap_go;

    if (!run || clear || snap_go || tmr_fire || sample_period == 32'd0)
      timer_d = 32'd0;
    else
      timer_d = timer_q + 32'd1;

    // gap_q counts cycles since the last trigger, saturating once spacing is satisfied.
    if (snap_evt)       gap_d = '0;
    else if (gap_ok)    gap_d = gap_q;
    else                gap_d = gap_q + GAP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      bytes_q          <= '0;
      good_q           <= '0;
      bad_q            <= '0;
      timer_q          <= '0;
      gap_q            <= GAP_MAX;
      pend_q           <= 1'b0;
      snapshot_data    <= '0;
      snapshot_trigger <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      gap_q            <= gap_d;
      pend_q           <= pend_d;
      snapshot_trigger <= snap_evt;
      if (clear) begin
        bytes_q <= '0;
        good_q  <= '0;
        bad_q   <= '0;
      end else begin
        bytes_q <= bytes_n;
        good_q  <= good_n;
        bad_q   <= bad_n;
      end
      if (snap_evt)
        snapshot_data <= {bad_n, good_n, bytes_n};
    end
  end

endmodule
